// File: rtl/pht_update_scheduler.sv
// Pattern-history-table port scheduler: arbitrates decode lookups against queued EX
// feedback updates (read-modify-write). Optional gshare indexing via PHT_SCHED_GSHARE_EN.
module pht_update_scheduler #(
  parameter int INDEX_BITS = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  output logic                  o_req_stall,
  output logic                  o_pred_valid,
  output logic                  o_pred_taken,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  logic                  i_fb_outcome,
  output logic                  o_fb_full,
  output logic [7:0]            o_drop_count,
  output logic                  o_pht_en,
  output logic                  o_pht_we,
  output logic [INDEX_BITS-1:0] o_pht_addr,
  output logic [1:0]            o_pht_wdata,
  input  logic [1:0]            i_pht_rdata
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int ENT_BITS = INDEX_BITS + 1;
  localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_PEND = 2'd2} state_t;

  state_t                state, next_state;
  logic [ENT_BITS-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr, rd_ptr;
  logic [PTR_BITS:0]     count;
  logic [1:0]            held;
  logic [7:0]            drop_count;
  logic                  pred_valid;

  logic [INDEX_BITS-1:0] req_index, fb_index, head_index;
  logic                  head_outcome;
  logic                  empty, full, fsm_needs, lookup_grant, fsm_grant;
  logic                  push, pop, drop;
  logic [1:0]            new_val;
  logic                  pht_en, pht_we;
  logic [INDEX_BITS-1:0] pht_addr;
  logic [1:0]            pht_wdata;
  logic                  unused_pc_bits;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
  endfunction

`ifdef PHT_SCHED_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr;

  // Global history shifts in each accepted outcome; indices use the pre-shift value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (push) begin
      ghr <= {ghr[INDEX_BITS-2:0], i_fb_outcome};
    end else begin
      ghr <= ghr;
    end
  end

  assign req_index = i_req_pc[INDEX_BITS+1:2] ^ ghr;
  assign fb_index  = i_fb_pc[INDEX_BITS+1:2] ^ ghr;
`else
  assign req_index = i_req_pc[INDEX_BITS+1:2];
  assign fb_index  = i_fb_pc[INDEX_BITS+1:2];
`endif

  assign unused_pc_bits = ^{i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_req_pc[1:0],
                            i_fb_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_fb_pc[1:0]};

  assign head_index   = fifo_mem[rd_ptr][ENT_BITS-1:1];
  assign head_outcome = fifo_mem[rd_ptr][0];
  assign empty        = (count == '0);
  assign full         = (count == FULL_COUNT);

  // A full queue forces the update engine onto the port ahead of lookups
  assign fsm_needs    = (state != IDLE) || !empty;
  assign lookup_grant = i_req_valid && !(full && fsm_needs);
  assign fsm_grant    = fsm_needs && !lookup_grant;
  assign pop          = fsm_grant && ((state == RD_WAIT) || (state == WR_PEND));
  assign push         = i_fb_valid && (!full || pop);
  assign drop         = i_fb_valid && !push;
  assign new_val      = sat_update(i_pht_rdata, head_outcome);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = fsm_grant ? RD_WAIT : IDLE;
      RD_WAIT: next_state = fsm_grant ? IDLE : WR_PEND;
      WR_PEND: next_state = fsm_grant ? IDLE : WR_PEND;
      default: next_state = IDLE;
    endcase
  end

  // PHT port drive: lookup, or the FSM's read / write of the queue head
  always_comb begin
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = '0;
    pht_wdata = 2'b00;
    if (lookup_grant) begin
      pht_en   = 1'b1;
      pht_addr = req_index;
    end else if (fsm_grant) begin
      case (state)
        IDLE: begin
          pht_en   = 1'b1;
          pht_addr = head_index;
        end
        RD_WAIT: begin
          pht_en    = 1'b1;
          pht_we    = 1'b1;
          pht_addr  = head_index;
          pht_wdata = new_val;
        end
        WR_PEND: begin
          pht_en    = 1'b1;
          pht_we    = 1'b1;
          pht_addr  = head_index;
          pht_wdata = held;
        end
        default: begin
          pht_en = 1'b0;
        end
      endcase
    end else begin
      pht_en = 1'b0;
    end
  end

  // Reset masks every port access so an interrupted update never writes
  assign o_pht_en     = pht_en & ~rst;
  assign o_pht_we     = pht_we & ~rst;
  assign o_pht_addr   = rst ? '0 : pht_addr;
  assign o_pht_wdata  = rst ? 2'b00 : pht_wdata;
  assign o_req_stall  = i_req_valid & ~lookup_grant & ~rst;
  assign o_pred_valid = pred_valid;
  assign o_pred_taken = pred_valid & i_pht_rdata[1];
  assign o_fb_full    = full;
  assign o_drop_count = drop_count;

  // Prediction valid trails the granted lookup by one cycle; counter value held for WR_PEND
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid <= 1'b0;
      held       <= 2'b00;
    end else begin
      pred_valid <= lookup_grant;
      held       <= (state == RD_WAIT) ? new_val : held;
    end
  end

  // Queue payload storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {fb_index, i_fb_outcome};
    end
  end

  // Queue pointers, occupancy and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= 8'd0;
    end else begin
      wr_ptr <= push ? wr_ptr + PTR_BITS'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PTR_BITS'(1) : rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + (PTR_BITS+1)'(1);
        2'b01:   count <= count - (PTR_BITS+1)'(1);
        default: count <= count;
      endcase
      if (drop && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end else begin
        drop_count <= drop_count;
      end
    end
  end

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed self-checking bench for pht_update_scheduler; the PHT read data is
// driven by hand at each step.
module tb_pht_update_scheduler;

  logic        clk;
  logic        rst;
  logic        i_req_valid;
  logic [31:0] i_req_pc;
  logic        o_req_stall;
  logic        o_pred_valid;
  logic        o_pred_taken;
  logic        i_fb_valid;
  logic [31:0] i_fb_pc;
  logic        i_fb_outcome;
  logic        o_fb_full;
  logic [7:0]  o_drop_count;
  logic        o_pht_en;
  logic        o_pht_we;
  logic [7:0]  o_pht_addr;
  logic [1:0]  o_pht_wdata;
  logic [1:0]  i_pht_rdata;

  int checks = 0;
  int errors = 0;

  pht_update_scheduler #(.INDEX_BITS(8), .FIFO_DEPTH(4), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_pc(i_req_pc), .o_req_stall(o_req_stall),
    .o_pred_valid(o_pred_valid), .o_pred_taken(o_pred_taken),
    .i_fb_valid(i_fb_valid), .i_fb_pc(i_fb_pc), .i_fb_outcome(i_fb_outcome),
    .o_fb_full(o_fb_full), .o_drop_count(o_drop_count),
    .o_pht_en(o_pht_en), .o_pht_we(o_pht_we), .o_pht_addr(o_pht_addr),
    .o_pht_wdata(o_pht_wdata), .i_pht_rdata(i_pht_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Port check: address only meaningful when enabled, data only when writing
  task automatic chk_port(input string tag, input logic en, input logic we,
                          input logic [7:0] addr, input logic [1:0] wdata);
    chk({tag, ".en"}, o_pht_en, en);
    chk({tag, ".we"}, o_pht_we, we);
    if (en) chk({tag, ".addr"}, o_pht_addr, addr);
    if (we) chk({tag, ".wdata"}, o_pht_wdata, wdata);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; i_req_valid = 1'b1; i_req_pc = 32'h0;
    i_fb_valid = 1'b0; i_fb_pc = 32'h0; i_fb_outcome = 1'b0; i_pht_rdata = 2'b00;
    @(negedge clk); #1;
    chk("rst.stall", o_req_stall, 1'b0);
    chk("rst.pred_valid", o_pred_valid, 1'b0);
    chk("rst.full", o_fb_full, 1'b0);
    chk("rst.drop", o_drop_count, 8'd0);
    chk_port("rst", 1'b0, 1'b0, 8'h00, 2'b00);
    rst = 1'b0; i_req_valid = 1'b0;
    tick;

`ifdef PHT_SCHED_GSHARE_EN
    // gshare: two taken outcomes give GHR=3, so lookup pc 0 maps to index 3
    i_fb_valid = 1'b1; i_fb_pc = 32'h0; i_fb_outcome = 1'b1;
    tick;
    tick;
    i_fb_valid = 1'b0; i_req_valid = 1'b1; i_req_pc = 32'h0; #1;
    chk_port("gs.lookup", 1'b1, 1'b0, 8'h03, 2'b00);
    chk("gs.stall", o_req_stall, 1'b0);
    tick;
    i_req_valid = 1'b0;
`else
    // Single update: read 0x10, then write 01+1 = 10
    i_fb_valid = 1'b1; i_fb_pc = 32'h40; i_fb_outcome = 1'b1; #1;
    chk_port("a.idle", 1'b0, 1'b0, 8'h00, 2'b00);
    tick;
    i_fb_valid = 1'b0; #1;
    chk_port("a.rd", 1'b1, 1'b0, 8'h10, 2'b00);
    tick;
    i_pht_rdata = 2'b01; #1;
    chk_port("a.wr", 1'b1, 1'b1, 8'h10, 2'b10);
    tick; #1;
    chk_port("a.done", 1'b0, 1'b0, 8'h00, 2'b00);

    // Lookup pc 0x80 -> index 0x20, prediction next cycle
    i_req_valid = 1'b1; i_req_pc = 32'h80; #1;
    chk_port("b.lookup", 1'b1, 1'b0, 8'h20, 2'b00);
    chk("b.stall", o_req_stall, 1'b0);
    tick;
    i_req_valid = 1'b0; i_pht_rdata = 2'b11; #1;
    chk("b.pred_valid", o_pred_valid, 1'b1);
    chk("b.pred_taken", o_pred_taken, 1'b1);
    tick; #1;
    chk("b.pred_valid_drop", o_pred_valid, 1'b0);

    // Saturation at both ends, plus a plain decrement
    i_fb_valid = 1'b1; i_fb_pc = 32'h44; i_fb_outcome = 1'b1;
    tick;
    i_fb_valid = 1'b0; #1;
    chk_port("c.rd_hi", 1'b1, 1'b0, 8'h11, 2'b00);
    tick;
    i_pht_rdata = 2'b11; #1;
    chk_port("c.sat_hi", 1'b1, 1'b1, 8'h11, 2'b11);
    tick;
    i_fb_valid = 1'b1; i_fb_pc = 32'h48; i_fb_outcome = 1'b0;
    tick;
    i_fb_valid = 1'b0;
    tick;
    i_pht_rdata = 2'b00; #1;
    chk_port("c.sat_lo", 1'b1, 1'b1, 8'h12, 2'b00);
    tick;
    i_fb_valid = 1'b1; i_fb_pc = 32'h4C; i_fb_outcome = 1'b0;
    tick;
    i_fb_valid = 1'b0;
    tick;
    i_pht_rdata = 2'b10; #1;
    chk_port("c.dec", 1'b1, 1'b1, 8'h13, 2'b01);
    tick;

    // Continuous lookups while 4 feedbacks queue up, forced update, WR_PEND hold
    i_req_valid = 1'b1; i_req_pc = 32'h100;
    i_fb_valid = 1'b1; i_fb_pc = 32'h40; i_fb_outcome = 1'b1; #1;
    chk("d.stall0", o_req_stall, 1'b0);
    tick;
    i_fb_pc = 32'h44; i_fb_outcome = 1'b1; #1;
    chk_port("d.lookup1", 1'b1, 1'b0, 8'h40, 2'b00);
    chk("d.stall1", o_req_stall, 1'b0);
    tick;
    i_fb_pc = 32'h48; i_fb_outcome = 1'b0;
    tick;
    i_fb_pc = 32'h4C; i_fb_outcome = 1'b1; #1;
    chk("d.full3", o_fb_full, 1'b0);
    tick;
    i_fb_valid = 1'b0; #1;
    chk("d.full4", o_fb_full, 1'b1);
    chk("d.force_rd_stall", o_req_stall, 1'b1);
    chk_port("d.force_rd", 1'b1, 1'b0, 8'h10, 2'b00);
    tick;
    i_pht_rdata = 2'b01; #1;
    chk("d.force_wr_stall", o_req_stall, 1'b1);
    chk("d.pred_none", o_pred_valid, 1'b0);
    chk_port("d.force_wr", 1'b1, 1'b1, 8'h10, 2'b10);
    tick; #1;
    chk("d.full_after_pop", o_fb_full, 1'b0);
    chk("d.stall_after_pop", o_req_stall, 1'b0);
    chk_port("d.lookup_wins", 1'b1, 1'b0, 8'h40, 2'b00);
    tick;
    i_req_valid = 1'b0; #1;
    chk_port("d.rd2", 1'b1, 1'b0, 8'h11, 2'b00);
    tick;
    i_req_valid = 1'b1; i_req_pc = 32'h44; i_pht_rdata = 2'b10; #1;
    chk("d.inflight_stall", o_req_stall, 1'b0);
    chk_port("d.inflight_lookup", 1'b1, 1'b0, 8'h11, 2'b00);
    tick;
    i_req_valid = 1'b0; i_pht_rdata = 2'b01; #1;
    chk("d.inflight_pred_valid", o_pred_valid, 1'b1);
    chk("d.inflight_pred_taken", o_pred_taken, 1'b0);
    chk_port("d.wr_pend", 1'b1, 1'b1, 8'h11, 2'b11);
    tick; #1;
    chk_port("d.rd3", 1'b1, 1'b0, 8'h12, 2'b00);
    tick;
    i_pht_rdata = 2'b10; #1;
    chk_port("d.wr3", 1'b1, 1'b1, 8'h12, 2'b01);
    tick; #1;
    chk_port("d.rd4", 1'b1, 1'b0, 8'h13, 2'b00);
    tick;
    i_pht_rdata = 2'b11; #1;
    chk_port("d.wr4", 1'b1, 1'b1, 8'h13, 2'b11);
    tick; #1;
    chk_port("d.drained", 1'b0, 1'b0, 8'h00, 2'b00);
    chk("d.drained_full", o_fb_full, 1'b0);

    // Drops while full (3 cycles without a pop), then reset during WR_PEND
    i_pht_rdata = 2'b00;
    for (int k = 0; k < 9; k++) begin
      i_req_valid = 1'b1; i_req_pc = 32'h100;
      i_fb_valid = 1'b1; i_fb_pc = 32'h200 + 32'(4 * k); i_fb_outcome = 1'b1; #1;
      if (k == 4) begin
        chk("e.full", o_fb_full, 1'b1);
        chk("e.stall", o_req_stall, 1'b1);
        chk_port("e.force_rd", 1'b1, 1'b0, 8'h80, 2'b00);
      end
      if (k == 5) chk("e.drop1", o_drop_count, 8'd1);
      if (k == 7) chk("e.drop2", o_drop_count, 8'd2);
      tick;
    end
    i_fb_valid = 1'b0; i_req_valid = 1'b0; #1;
    chk("e.drop3", o_drop_count, 8'd3);
    chk_port("e.wr82", 1'b1, 1'b1, 8'h82, 2'b01);
    tick; #1;
    chk_port("e.rd83", 1'b1, 1'b0, 8'h83, 2'b00);
    chk("e.not_full", o_fb_full, 1'b0);
    tick;
    i_req_valid = 1'b1; i_req_pc = 32'h100; #1;
    chk("e.rdwait_stall", o_req_stall, 1'b0);
    chk_port("e.rdwait_lookup", 1'b1, 1'b0, 8'h40, 2'b00);
    tick;
    i_fb_valid = 1'b1; i_fb_pc = 32'h300; i_fb_outcome = 1'b0; #1;
    chk("e.pend_stall", o_req_stall, 1'b0);
    chk_port("e.pend_lookup", 1'b1, 1'b0, 8'h40, 2'b00);
    tick;
    i_fb_valid = 1'b0; #1;
    chk("e.pend_full", o_fb_full, 1'b1);
    chk("e.pend_force_stall", o_req_stall, 1'b1);
    chk_port("e.pend_force_wr", 1'b1, 1'b1, 8'h83, 2'b01);
    rst = 1'b1; #1;
    chk_port("e.rst_nowrite", 1'b0, 1'b0, 8'h00, 2'b00);
    chk("e.rst_full", o_fb_full, 1'b0);
    chk("e.rst_drop", o_drop_count, 8'd0);
    chk("e.rst_stall", o_req_stall, 1'b0);
    chk("e.rst_pred", o_pred_valid, 1'b0);
    tick;
    rst = 1'b0; i_req_valid = 1'b0; #1;
    chk_port("e.post_rst", 1'b0, 1'b0, 8'h00, 2'b00);
    tick; #1;
    chk_port("e.post_rst_idle", 1'b0, 1'b0, 8'h00, 2'b00);
    chk("e.post_rst_drop", o_drop_count, 8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pht_update_scheduler.md
PHT_UPDATE_SCHEDULER -- requirements
Module: pht_update_scheduler

Interface
REQ-001 Parameter INDEX_BITS, default 8, SHALL set the pattern-history-table index width (2^INDEX_BITS 2-bit counters).
REQ-002 Parameter FIFO_DEPTH, default 4, power of 2, SHALL set the feedback-queue depth.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 i_req_valid  in  1  decode-stage prediction lookup request.
REQ-007 i_req_pc  in  ADDR_WIDTH  PC of the branch being looked up.
REQ-008 o_req_stall  out  1  lookup not granted this cycle; decode holds the request.
REQ-009 o_pred_valid / o_pred_taken  out  1 / 1  prediction result, one cycle after the lookup is granted.
REQ-010 i_fb_valid / i_fb_pc / i_fb_outcome  in  1 / ADDR_WIDTH / 1  EX feedback; outcome 1 = taken.
REQ-011 o_fb_full  out  1  feedback queue holds FIFO_DEPTH entries.
REQ-012 o_drop_count  out  8  saturating count of feedback entries dropped.
REQ-013 o_pht_en / o_pht_we / o_pht_addr / o_pht_wdata  out  1 / 1 / INDEX_BITS / 2  single-port PHT access.
REQ-014 i_pht_rdata  in  2  PHT read data, valid the cycle after a read access (en=1, we=0).

Function
REQ-015 Index SHALL be pc[INDEX_BITS+1:2]; feedback is queued as {index, outcome}, with the index computed at push time.
REQ-016 The PHT port SHALL carry at most one access per cycle; a granted lookup drives en=1, we=0 and addr = lookup index.
REQ-017 Arbitration SHALL grant the port to i_req_valid unless force_upd = o_fb_full is active and the FSM needs the port; otherwise the FSM is granted.
REQ-018 o_req_stall SHALL equal i_req_valid AND NOT lookup-granted; o_pred_valid SHALL be 1 exactly one cycle after a granted lookup, with o_pred_taken = i_pht_rdata[1].
REQ-019 FSM states SHALL be IDLE, RD_WAIT and WR_PEND.
REQ-020 IDLE: if the queue is non-empty and the FSM is granted, issue a read of the head index and go to RD_WAIT; otherwise stay in IDLE.
REQ-021 RD_WAIT: latch new = i_pht_rdata saturating-incremented (taken) or saturating-decremented (not taken), limits 2'b11 and 2'b00.
REQ-022 In RD_WAIT, if granted, write new to the head index, pop, and go to IDLE; otherwise go to WR_PEND holding new.
REQ-023 WR_PEND: when granted, write the held value, pop, and go to IDLE; the write SHALL use the held value without a re-read.
REQ-024 Push on i_fb_valid SHALL be accepted if the queue is not full, or if a pop occurs in the same cycle (simultaneous push+pop at full keeps count = FIFO_DEPTH).
REQ-025 Otherwise the entry SHALL be dropped and o_drop_count incremented, saturating at 255.
REQ-026 Queue pointers SHALL wrap modulo FIFO_DEPTH, and occupancy SHALL range 0..FIFO_DEPTH.
REQ-027 A lookup to an index with an in-flight update SHALL read the stored (pre-update) value, with no bypass.

Reset
REQ-028 On rst all outputs SHALL be 0, the FSM SHALL be in IDLE, queue occupancy and pointers SHALL be 0, o_drop_count SHALL be 0, and the GHR (if compiled) SHALL be 0.
REQ-029 Reset asserted mid-update SHALL discard queued and in-flight updates without issuing any PHT write; the PHT contents are not cleared by this block.

Configuration
REQ-030 With PHT_SCHED_GSHARE_EN defined, an INDEX_BITS global history register SHALL shift in i_fb_outcome on each accepted push.
REQ-031 With PHT_SCHED_GSHARE_EN defined, lookup and push indices SHALL be pc[INDEX_BITS+1:2] XOR GHR, using the GHR value before that cycle's shift.
REQ-032 Without PHT_SCHED_GSHARE_EN, no GHR SHALL exist and the index SHALL be pc bits only.

Verification
REQ-033 After reset, feedback pc=0x40, outcome=1 with no lookups, and rdata=2'b01 -> read addr 0x10, then the next cycle a write of addr 0x10 with wdata 2'b10, returning to IDLE.
REQ-034 Lookup pc=0x80 with PHT[0x20]=2'b11 -> cycle t: en=1, we=0, addr 0x20, stall=0; cycle t+1: o_pred_valid=1, o_pred_taken=1.
REQ-035 Saturation: outcome=1 with rdata=2'b11 -> wdata 2'b11; outcome=0 with rdata=2'b00 -> wdata 2'b00.
REQ-036 Continuous lookups with 4 feedbacks queued -> o_fb_full=1, updates forced, o_req_stall=1 on each update-access cycle, and all 4 writes complete.
REQ-037 With the queue full in IDLE, 3 extra pushes -> o_drop_count=3; rst asserted while in WR_PEND -> no write, o_fb_full=0 and o_drop_count=0 immediately.
REQ-038 With PHT_SCHED_GSHARE_EN, feedback outcomes 1,1 and then lookup pc=0x0 -> addr 0x03.
